// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the pipeline stage register family.
//   DefaultDataWidth       - default payload width in bits
//   DefaultStallCountWidth - default width of the saturating stall counter
//   MaxDataWidth           - widest payload supported (helper word width)
//   out_action_e           - what the output register does on the next edge
//   zero_bubble()          - clears the control-field bits of a payload
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int unsigned DefaultDataWidth       = 32;
    localparam int unsigned DefaultStallCountWidth = 16;
    localparam int unsigned MaxDataWidth           = 256;

    typedef logic [MaxDataWidth-1:0] max_word_t;

    // Next-edge behaviour of the output register.
    typedef enum logic [1:0] {
        ActHold     = 2'd0,  // keep payload (stalled or idle)
        ActLoadIn   = 2'd1,  // take the upstream payload
        ActLoadSkid = 2'd2,  // take the payload parked in the skid slot
        ActBubble   = 2'd3   // go empty, control fields forced to zero
    } out_action_e;

    // A bubble keeps the datapath bits but zeroes every bit set in the mask,
    // so downstream control decoders see a harmless all-zero control word.
    function automatic max_word_t zero_bubble(input max_word_t data, input max_word_t mask);
        return data & ~mask;
    endfunction

endpackage

// File: rtl/pipeline_stage_register_if.sv
// -----------------------------------------------------------------------------
// pipeline_stage_register_if
// Handshake bundle around one pipeline stage register.
//   in_valid / in_ready / in_data    - upstream side of the stage
//   out_valid / out_ready / out_data - downstream side of the stage
// Modports:
//   slave  - the stage itself (consumes in_*, produces out_*)
//   master - the environment (produces in_*, consumes out_*)
// -----------------------------------------------------------------------------
interface pipeline_stage_register_if #(
    parameter int unsigned DATA_WIDTH = pipeline_pkg::DefaultDataWidth
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/pipeline_skid_slot.sv
// -----------------------------------------------------------------------------
// pipeline_skid_slot
// One-entry register with a valid flag, used to park a payload that arrives
// while the stage output is stalled.
// Ports:
//   clock     - rising-edge clock
//   reset     - synchronous active-high reset (empties the slot, zeroes data)
//   i_clear   - empties the slot (flush); wins over load and unload
//   i_load    - capture i_data into the slot
//   i_unload  - slot contents consumed this cycle
//   i_data    - payload to capture
//   o_valid   - slot holds a payload
//   o_data    - parked payload
// -----------------------------------------------------------------------------
module pipeline_skid_slot
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic                  i_unload,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_valid_d;
    logic [DATA_WIDTH-1:0] w_data_d;

    always_comb begin
        w_valid_d = r_valid;
        w_data_d  = r_data;
        if (i_clear) begin
            w_valid_d = 1'b0;
        end else if (i_load) begin
            w_valid_d = 1'b1;
            w_data_d  = i_data;
        end else if (i_unload) begin
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_valid_d;
            r_data  <= w_data_d;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipeline_stage_register.sv
// -----------------------------------------------------------------------------
// pipeline_stage_register
// Registered valid/ready pipeline stage with flush, control-field bubbles and
// a saturating stall counter.
// Parameters:
//   DATA_WIDTH        - payload width (1..256)
//   CONTROL_MASK      - payload bits zeroed whenever out_valid is low
//   STALL_COUNT_WIDTH - width of stall_count
// Ports:
//   clock       - rising-edge clock
//   reset       - synchronous active-high reset, overrides everything
//   flush       - drop every held payload and refuse this cycle's input
//   stall_count - saturating count of cycles with out_valid=1, out_ready=0
//   bus         - handshake bundle (slave side): in_valid/in_ready/in_data,
//                 out_valid/out_ready/out_data
// Configuration:
//   PIPELINE_STAGE_SKID_BUFFER_EN - adds a one-entry skid slot so that in_ready
//   no longer depends combinationally on out_ready. Without it the stage is a
//   single register and in_ready = out_ready | ~out_valid.
// -----------------------------------------------------------------------------
module pipeline_stage_register
    import pipeline_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH        = DefaultDataWidth,
    parameter logic [DATA_WIDTH-1:0] CONTROL_MASK      = '0,
    parameter int unsigned           STALL_COUNT_WIDTH = DefaultStallCountWidth
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    output logic [STALL_COUNT_WIDTH-1:0] stall_count,
    pipeline_stage_register_if.slave     bus
);

    // Output register state.
    logic                         r_valid;
    logic [DATA_WIDTH-1:0]        r_data;
    logic [STALL_COUNT_WIDTH-1:0] r_stall_count;

    // Next-state and decode.
    logic                         w_valid_d;
    logic [DATA_WIDTH-1:0]        w_data_d;
    logic [STALL_COUNT_WIDTH-1:0] w_stall_count_d;
    logic                         w_out_free;
    logic                         w_out_stalled;
    logic                         w_in_ready;
    logic                         w_accept;
    logic [DATA_WIDTH-1:0]        w_bubble_data;
    out_action_e                  w_action;

    // Skid view; constant-empty when the slot is not built.
    logic                         w_skid_valid;
    logic [DATA_WIDTH-1:0]        w_skid_data;

    // Output register can take a new payload on the next edge.
    assign w_out_free    = ~r_valid | bus.out_ready;
    assign w_out_stalled = r_valid & ~bus.out_ready;

    assign w_bubble_data = DATA_WIDTH'(zero_bubble(max_word_t'(r_data),
                                                   max_word_t'(CONTROL_MASK)));

`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
    logic w_skid_load;
    logic w_skid_unload;

    // Ready is the registered "slot empty" flag; reset and flush only gate it
    // down, so out_ready never reaches in_ready.
    assign w_in_ready = ~reset & ~flush & ~w_skid_valid;
    assign w_accept   = bus.in_valid & w_in_ready;

    // A payload accepted while the output is stalled parks in the slot. The
    // slot must be empty to accept, so load and unload never coincide.
    assign w_skid_load   = w_accept & ~w_out_free;
    assign w_skid_unload = w_skid_valid & w_out_free;

    pipeline_skid_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_slot (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (flush),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_data   (bus.in_data),
        .o_valid  (w_skid_valid),
        .o_data   (w_skid_data)
    );
`else
    assign w_in_ready   = ~reset & ~flush & w_out_free;
    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_skid_valid = 1'b0;
    assign w_skid_data  = '0;
`endif

    // Output register action. Flush beats everything; a parked skid payload
    // is older than anything upstream, so it goes first to keep order.
    always_comb begin
        w_action = ActHold;
        if (flush) begin
            w_action = ActBubble;
        end else if (w_out_free) begin
            if (w_skid_valid) begin
                w_action = ActLoadSkid;
            end else if (w_accept) begin
                w_action = ActLoadIn;
            end else begin
                w_action = ActBubble;
            end
        end
    end

    always_comb begin
        w_valid_d = r_valid;
        w_data_d  = r_data;
        unique case (w_action)
            ActHold: begin
                w_valid_d = r_valid;
                w_data_d  = r_data;
            end
            ActLoadIn: begin
                w_valid_d = 1'b1;
                w_data_d  = bus.in_data;
            end
            ActLoadSkid: begin
                w_valid_d = 1'b1;
                w_data_d  = w_skid_data;
            end
            ActBubble: begin
                w_valid_d = 1'b0;
                w_data_d  = w_bubble_data;
            end
            default: begin
                w_valid_d = 1'b0;
                w_data_d  = w_bubble_data;
            end
        endcase
    end

    // Saturating stall counter; flush does not clear it.
    always_comb begin
        w_stall_count_d = r_stall_count;
        if (w_out_stalled && !(&r_stall_count)) begin
            w_stall_count_d = r_stall_count + STALL_COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_stall_count <= '0;
        end else begin
            r_valid       <= w_valid_d;
            r_data        <= w_data_d;
            r_stall_count <= w_stall_count_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stage_register
// Directed bench for pipeline_stage_register with CONTROL_MASK=0xF and a 4-bit
// stall counter. Works for both the plain and the skid-buffer build.
// -----------------------------------------------------------------------------
module tb_pipeline_stage_register;

    localparam int unsigned     DW   = 32;
    localparam logic [DW-1:0]   MASK = 32'h0000_000F;
    localparam int unsigned     SCW  = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           flush;
    logic [SCW-1:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_stage_register_if #(.DATA_WIDTH(DW)) bus ();

    pipeline_stage_register #(
        .DATA_WIDTH        (DW),
        .CONTROL_MASK      (MASK),
        .STALL_COUNT_WIDTH (SCW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .stall_count (stall_count),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEAD_BEEF;
        bus.out_ready = 1'b0;
        cycle(); cycle(); cycle();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 32'h0) begin n_fail++;
            $display("FAIL reset_data: got %h want 00000000", bus.out_data); end
        n_checks++; if (stall_count !== 4'd0) begin n_fail++;
            $display("FAIL reset_stall: got %0d want 0", stall_count); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++;
            $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        reset         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++;
            $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_single();
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h1234_5678;
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++;
            $display("FAIL single_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_data !== 32'h1234_5678) begin n_fail++;
            $display("FAIL single_data: got %h want 12345678", bus.out_data); end
        n_checks++; if (stall_count !== 4'd0) begin n_fail++;
            $display("FAIL single_stall: got %0d want 0", stall_count); end
        cycle();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++;
            $display("FAIL single_drain_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 32'h1234_5670) begin n_fail++;
            $display("FAIL single_bubble_data: got %h want 12345670", bus.out_data); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [3];
        vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vals[i];
            cycle();
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== vals[i]) begin n_fail++;
                $display("FAIL b2b_%0d: got valid=%b data=%h want valid=1 data=%h",
                         i, bus.out_valid, bus.out_data, vals[i]); end
        end
        bus.in_valid = 1'b0;
        cycle();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin n_fail++;
            $display("FAIL b2b_end: got valid=%b data=%h want valid=0 data=00000000",
                     bus.out_valid, bus.out_data); end
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA5;
        cycle();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5) begin n_fail++;
            $display("FAIL stall_load: got valid=%b data=%h want valid=1 data=000000a5",
                     bus.out_valid, bus.out_data); end
        bus.in_data = 32'hB6;
        #1;
`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++;
            $display("FAIL stall_skid_ready: got %b want 1", bus.in_ready); end
`else
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++;
            $display("FAIL stall_ready: got %b want 0", bus.in_ready); end
`endif
        for (int i = 1; i <= 5; i++) begin
            cycle();
`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
            bus.in_valid = 1'b0;  // B6 went into the skid slot on the first edge
`endif
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5 ||
                            stall_count !== SCW'(i)) begin n_fail++;
                $display("FAIL stall_hold_%0d: got valid=%b data=%h cnt=%0d want 1/a5/%0d",
                         i, bus.out_valid, bus.out_data, stall_count, i); end
        end
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++;
            $display("FAIL stall_full_ready: got %b want 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hB6) begin n_fail++;
            $display("FAIL stall_second: got valid=%b data=%h want valid=1 data=000000b6",
                     bus.out_valid, bus.out_data); end
        n_checks++; if (stall_count !== 4'd5) begin n_fail++;
            $display("FAIL stall_count: got %0d want 5", stall_count); end
        cycle();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'hB0) begin n_fail++;
            $display("FAIL stall_drain: got valid=%b data=%h want valid=0 data=000000b0",
                     bus.out_valid, bus.out_data); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hFF;
        cycle();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFF) begin n_fail++;
            $display("FAIL flush_load: got valid=%b data=%h want valid=1 data=000000ff",
                     bus.out_valid, bus.out_data); end
        // Skid build parks EE here; plain build refuses it.
        bus.in_data = 32'hEE;
        cycle();
        bus.in_valid = 1'b0;
        n_checks++; if (stall_count !== 4'd6) begin n_fail++;
            $display("FAIL flush_pre_stall: got %0d want 6", stall_count); end
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h77;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++;
            $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
        cycle();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++;
            $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 32'hF0) begin n_fail++;
            $display("FAIL flush_bubble: got %h want 000000f0", bus.out_data); end
        n_checks++; if (stall_count !== 4'd7) begin n_fail++;
            $display("FAIL flush_stall_kept: got %0d want 7", stall_count); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++;
                $display("FAIL flush_no_emit_%0d: got valid=%b data=%h want valid=0",
                         i, bus.out_valid, bus.out_data); end
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h3C;
        cycle();
        bus.in_data = 32'h5A;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            bus.in_valid = 1'b0;
            exp_cnt = (7 + i > 15) ? 15 : 7 + i;
            n_checks++; if (stall_count !== SCW'(exp_cnt) || bus.out_data !== 32'h3C) begin
                n_fail++;
                $display("FAIL sat_%0d: got cnt=%0d data=%h want cnt=%0d data=0000003c",
                         i, stall_count, bus.out_data, exp_cnt); end
        end
        reset = 1'b1;
        cycle();
        n_checks++; if (bus.out_valid !== 1'b0 || stall_count !== 4'd0 ||
                        bus.out_data !== 32'h0) begin n_fail++;
            $display("FAIL sat_reset: got valid=%b cnt=%0d data=%h want 0/0/00000000",
                     bus.out_valid, stall_count, bus.out_data); end
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++;
                $display("FAIL sat_discard_%0d: got valid=%b data=%h want valid=0",
                         i, bus.out_valid, bus.out_data); end
        end
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
